hyper_trx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single Hyperbus PHY transaction port among `NumReq` requesters, such as the AXI front-end and the register-interface master. It captures one transaction header per grant and forwards it to the PHY. It holds the grant until the PHY reports completion, then enforces a configurable chip-select recovery gap before the next issue. It sits between the requester-side protocol converters and the PHY/controller.

---
 rtl/hyper_trx_arbiter_pkg.sv | 20 ++
 rtl/hyper_trx_arbiter_if.sv | 39 +++
 rtl/hyper_trx_arbiter_rr_sel.sv | 32 +++
 rtl/hyper_trx_arbiter.sv | 93 +++++++++
 tb/tb_hyper_trx_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/hyper_trx_arbiter_pkg.sv
// hyper_trx_arb_pkg: shared types and constants for the Hyperbus transaction arbiter.
//   AddrWidth/BurstWidth/NumChips fix the header field widths used by every file,
//   hdr_t is the registered transaction header, state_t is the sequencer state.
package hyper_trx_arb_pkg;
   localparam int AddrWidth  = 32;
   localparam int BurstWidth = 16;
   localparam int NumChips   = 2;
   // A single chip still needs a one-bit index field.
   function automatic int cs_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   localparam int CsWidth = cs_width(NumChips);
   typedef struct packed {
      logic                  write;
      logic [AddrWidth-1:0]  addr;
      logic [BurstWidth-1:0] burst;
      logic [CsWidth-1:0]    cs;
   } hdr_t;
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;
endpackage

// File: rtl/hyper_trx_arbiter_if.sv
// hyper_trx_arbiter_if: requester, PHY and status signals of the transaction arbiter.
//   cfg_gap                          recovery gap config
//   req_valid/req_ready/req_write    per-requester handshake and direction
//   req_addr/req_burst/req_cs        per-requester header fields
//   phy_valid/phy_ready/phy_done     PHY header handshake and completion pulse
//   phy_write/phy_addr/phy_burst/phy_cs  registered header towards the PHY
//   grant/busy                       current owner and activity status
//   modport slave: arbiter side; modport master: requesters + PHY side.
interface hyper_trx_arbiter_if
   import hyper_trx_arb_pkg::*;
#(
   parameter int NumReq   = 2,
   parameter int GapWidth = 4
);
   logic [GapWidth-1:0]                 cfg_gap;
   logic [NumReq-1:0]                   req_valid;
   logic [NumReq-1:0]                   req_ready;
   logic [NumReq-1:0]                   req_write;
   logic [NumReq-1:0][AddrWidth-1:0]    req_addr;
   logic [NumReq-1:0][BurstWidth-1:0]   req_burst;
   logic [NumReq-1:0][CsWidth-1:0]      req_cs;
   logic                                phy_valid;
   logic                                phy_ready;
   logic                                phy_write;
   logic [AddrWidth-1:0]                phy_addr;
   logic [BurstWidth-1:0]               phy_burst;
   logic [CsWidth-1:0]                  phy_cs;
   logic                                phy_done;
   logic [NumReq-1:0]                   grant;
   logic                                busy;
   modport slave (
      input  cfg_gap, req_valid, req_write, req_addr, req_burst, req_cs, phy_ready, phy_done,
      output req_ready, phy_valid, phy_write, phy_addr, phy_burst, phy_cs, grant, busy
   );
   modport master (
      output cfg_gap, req_valid, req_write, req_addr, req_burst, req_cs, phy_ready, phy_done,
      input  req_ready, phy_valid, phy_write, phy_addr, phy_burst, phy_cs, grant, busy
   );
endinterface

// File: rtl/hyper_trx_arbiter_rr_sel.sv
// hyper_rr_sel: combinational round-robin selector.
//   req   in   pending requests
//   last  in   index of the previous winner; search starts at last+1 and wraps
//   gnt   out  one-hot winner (zero when no request)
//   idx   out  binary winner index
//   any   out  at least one request pending
module hyper_rr_sel
   import hyper_trx_arb_pkg::*;
#(
   parameter int NumReq = 2,
   localparam int IdxWidth = $clog2(NumReq)
) (
   input  logic [NumReq-1:0]   req,
   input  logic [IdxWidth-1:0] last,
   output logic [NumReq-1:0]   gnt,
   output logic [IdxWidth-1:0] idx,
   output logic                any
);
   // Walk from the farthest candidate to the nearest one so that the nearest
   // pending requester after last overwrites every other hit.
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = NumReq; i >= 1; i--) begin
         if (req[(int'(last) + i) % NumReq]) begin
            gnt = NumReq'(1) << ((int'(last) + i) % NumReq);
            idx = IdxWidth'((int'(last) + i) % NumReq);
         end
      end
   end
   assign any = |req;
endmodule

// File: rtl/hyper_trx_arbiter.sv
// hyper_trx_arbiter: round-robin owner selection and header sequencing for the
// shared Hyperbus PHY transaction port.
//   clk_i   in   clock
//   rst_ni  in   synchronous active-low reset
//   bus     slave modport: requester headers in, PHY header out, grant/busy status
// One header is captured per grant; the grant is held until the PHY reports
// done, followed by cfg_gap idle cycles before the next arbitration.
module hyper_trx_arbiter
   import hyper_trx_arb_pkg::*;
#(
   parameter int NumReq   = 2,
   parameter int GapWidth = 4
) (
   input logic               clk_i,
   input logic               rst_ni,
   hyper_trx_arbiter_if.slave bus
);
   localparam int IdxWidth = $clog2(NumReq);

   state_t              state_q, state_d;
   hdr_t                hdr_q, hdr_d;
   logic [NumReq-1:0]   grant_q, grant_d, win;
   logic [IdxWidth-1:0] last_q, last_d, win_idx;
   logic [GapWidth-1:0] cnt_q, cnt_d;
   logic                any;

   hyper_rr_sel #(.NumReq(NumReq)) u_sel (
      .req  (bus.req_valid),
      .last (last_q),
      .gnt  (win),
      .idx  (win_idx),
      .any  (any)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         hdr_q   <= '0;
         grant_q <= '0;
         last_q  <= IdxWidth'(NumReq - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      hdr_d         = hdr_q;
      grant_d       = grant_q;
      last_d        = last_q;
      cnt_d         = cnt_q;
      bus.req_ready = '0;
      case (state_q)
         IDLE: begin
            if (any) begin
               bus.req_ready = win;
               hdr_d = '{write: bus.req_write[win_idx], addr: bus.req_addr[win_idx],
                         burst: bus.req_burst[win_idx], cs: bus.req_cs[win_idx]};
               grant_d = win;
               last_d  = win_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = bus.phy_ready ? BUSY : ISSUE;
         BUSY: begin
            if (bus.phy_done) begin
               grant_d = '0;
               cnt_d   = bus.cfg_gap;
               state_d = (bus.cfg_gap == '0) ? IDLE : GAP;
            end
         end
         GAP: begin
            // The counter holds the remaining GAP cycles including this one.
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q <= GapWidth'(1)) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.phy_valid = state_q == ISSUE;
   assign bus.phy_write = hdr_q.write;
   assign bus.phy_addr  = hdr_q.addr;
   assign bus.phy_burst = hdr_q.burst;
   assign bus.phy_cs    = hdr_q.cs;
   assign bus.grant     = grant_q;
   assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_hyper_trx_arbiter.sv
// tb_hyper_trx_arbiter: directed self-checking bench for hyper_trx_arbiter
// (two-requester instance plus a three-requester instance for wrap-around).
module tb_hyper_trx_arbiter;
   import hyper_trx_arb_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   int   t_last = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hyper_trx_arbiter_if #(.NumReq(2)) a ();
   hyper_trx_arbiter_if #(.NumReq(3)) b ();

   hyper_trx_arbiter #(.NumReq(2)) u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(a));
   hyper_trx_arbiter #(.NumReq(3)) u_dut3 (.clk_i(clk), .rst_ni(rst_n), .bus(b));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      a.cfg_gap = '0; a.req_valid = '0; a.req_write = '0; a.req_addr = '0;
      a.req_burst = '0; a.req_cs = '0; a.phy_ready = 1'b0; a.phy_done = 1'b0;
      b.cfg_gap = '0; b.req_valid = '0; b.req_write = '0; b.req_addr = '0;
      b.req_burst = '0; b.req_cs = '0; b.phy_ready = 1'b0; b.phy_done = 1'b0;
      step; step;
      chk("rst_ready", 64'(a.req_ready), 64'd0);
      chk("rst_valid", 64'(a.phy_valid), 64'd0);
      chk("rst_grant", 64'(a.grant), 64'd0);
      chk("rst_busy",  64'(a.busy), 64'd0);
      chk("rst_hdr",   64'({a.phy_write, a.phy_addr, a.phy_burst, a.phy_cs}), 64'd0);
      rst_n = 1'b1;

      // single request after reset
      a.req_valid = 2'b01; a.req_write = 2'b01; a.req_addr[0] = 32'h800;
      a.req_burst[0] = 16'd4; a.req_cs[0] = 1'b1;
      #1;
      chk("t1_ready", 64'(a.req_ready), 64'b01);
      step;
      a.req_valid = 2'b00;
      #1;
      chk("t1_valid", 64'(a.phy_valid), 64'd1);
      chk("t1_addr",  64'(a.phy_addr), 64'h800);
      chk("t1_burst", 64'(a.phy_burst), 64'd4);
      chk("t1_write", 64'(a.phy_write), 64'd1);
      chk("t1_cs",    64'(a.phy_cs), 64'd1);
      chk("t1_grant", 64'(a.grant), 64'b01);
      chk("t1_ready_issue", 64'(a.req_ready), 64'd0);
      a.phy_ready = 1'b1;
      step;
      a.phy_ready = 1'b0;
      #1;
      chk("t1_busy_valid", 64'(a.phy_valid), 64'd0);
      chk("t1_busy_grant", 64'(a.grant), 64'b01);
      step; step;
      chk("t1_hold_grant", 64'(a.grant), 64'b01);
      a.phy_done = 1'b1;
      #1;
      chk("t1_done_grant", 64'(a.grant), 64'b01);
      step;
      a.phy_done = 1'b0;
      #1;
      chk("t1_after_grant", 64'(a.grant), 64'd0);
      chk("t1_after_busy",  64'(a.busy), 64'd0);

      // fairness: both requesters pending, gap 0, done on the sixth BUSY cycle
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      a.req_addr[0] = 32'h100; a.req_addr[1] = 32'h200;
      a.req_valid = 2'b11; a.phy_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         for (int w = 0; w < 20 && !a.phy_valid; w++) step;
         chk($sformatf("fair_valid%0d", k), 64'(a.phy_valid), 64'd1);
         chk($sformatf("fair_grant%0d", k), 64'(a.grant), k[0] ? 64'b10 : 64'b01);
         chk($sformatf("fair_addr%0d", k),  64'(a.phy_addr), k[0] ? 64'h200 : 64'h100);
         if (k > 0) chk($sformatf("fair_period%0d", k), 64'(cyc - t_last), 64'd8);
         t_last = cyc;
         repeat (6) step;
         a.phy_done = 1'b1;
         if (k == 3) a.req_valid = 2'b00;
         step;
         a.phy_done = 1'b0;
      end

      // gap enforcement with cfg_gap = 3; changing cfg_gap inside GAP must not matter
      a.cfg_gap = 4'd3; a.req_addr[0] = 32'h300; a.req_valid = 2'b01;
      #1;
      chk("gap_first_ready", 64'(a.req_ready), 64'b01);
      step;
      a.req_valid = 2'b10;
      step;
      a.phy_done = 1'b1;
      step;
      a.phy_done = 1'b0; a.cfg_gap = 4'd0;
      #1;
      chk("gap_n1_ready", 64'(a.req_ready), 64'd0);
      chk("gap_n1_busy",  64'(a.busy), 64'd1);
      chk("gap_n1_grant", 64'(a.grant), 64'd0);
      step;
      chk("gap_n2_ready", 64'(a.req_ready), 64'd0);
      step;
      chk("gap_n3_ready", 64'(a.req_ready), 64'd0);
      chk("gap_n3_valid", 64'(a.phy_valid), 64'd0);
      step;
      a.phy_ready = 1'b0;
      chk("gap_n4_ready", 64'(a.req_ready), 64'b10);
      chk("gap_n4_busy",  64'(a.busy), 64'd0);
      step;
      chk("gap_n5_valid", 64'(a.phy_valid), 64'd1);
      chk("gap_n5_grant", 64'(a.grant), 64'b10);

      // PHY backpressure for 10 cycles with a stray done pulse during ISSUE
      a.req_addr[1] = 32'hdead; a.req_valid = 2'b01;
      for (int i = 0; i < 10; i++) begin
         a.phy_done = (i == 4);
         step;
         chk($sformatf("bp_valid%0d", i), 64'(a.phy_valid), 64'd1);
         chk($sformatf("bp_addr%0d", i),  64'(a.phy_addr), 64'h200);
         chk($sformatf("bp_grant%0d", i), 64'(a.grant), 64'b10);
         chk($sformatf("bp_ready%0d", i), 64'(a.req_ready), 64'd0);
      end
      a.phy_done = 1'b0; a.phy_ready = 1'b1;
      step;
      a.phy_ready = 1'b0;
      #1;
      chk("bp_busy_valid", 64'(a.phy_valid), 64'd0);
      chk("bp_busy_grant", 64'(a.grant), 64'b10);

      // reset while BUSY
      rst_n = 1'b0; a.req_valid = 2'b00;
      step;
      rst_n = 1'b1;
      #1;
      chk("rb_ready", 64'(a.req_ready), 64'd0);
      chk("rb_valid", 64'(a.phy_valid), 64'd0);
      chk("rb_grant", 64'(a.grant), 64'd0);
      chk("rb_busy",  64'(a.busy), 64'd0);
      chk("rb_hdr",   64'({a.phy_write, a.phy_addr, a.phy_burst, a.phy_cs}), 64'd0);
      a.req_valid = 2'b11;
      #1;
      chk("rb_win_ready", 64'(a.req_ready), 64'b01);
      step;
      a.req_valid = 2'b10;
      chk("rb_win_grant", 64'(a.grant), 64'b01);
      chk("rb_win_addr",  64'(a.phy_addr), 64'h300);

      // wrap-around with three requesters: last grant 2, requesters 0 and 1 pending
      b.req_valid = 3'b100; b.req_addr[2] = 32'hc00;
      #1;
      chk("wrap_first_ready", 64'(b.req_ready), 64'b100);
      step;
      b.req_valid = 3'b000; b.phy_ready = 1'b1;
      chk("wrap_first_addr", 64'(b.phy_addr), 64'hc00);
      step;
      b.phy_ready = 1'b0; b.phy_done = 1'b1;
      step;
      b.phy_done = 1'b0; b.req_valid = 3'b011;
      #1;
      chk("wrap_ready", 64'(b.req_ready), 64'b001);
      step;
      chk("wrap_grant", 64'(b.grant), 64'b001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
